// File: rtl/char_uart_rx_if.sv
// char_uart_rx_if: groups the serial input line and the parallel character outputs of
// char_uart_rx into one bundle.
//   rx_in      - asynchronous serial line (idles high)
//   char_out   - last correctly received byte
//   char_valid - one-cycle strobe when char_out updates
//   frame_err  - one-cycle strobe on a bad stop bit
//   busy       - receiver is not idle
//   rx_count   - count of good characters (wraps)
// Modport master is the receiver side. Modport slave is the line driver / consumer side.
interface char_uart_rx_if;
    logic        rx_in;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] rx_count;

    modport master (
        input  rx_in,
        output char_out,
        output char_valid,
        output frame_err,
        output busy,
        output rx_count
    );

    modport slave (
        output rx_in,
        input  char_out,
        input  char_valid,
        input  frame_err,
        input  busy,
        input  rx_count
    );
endinterface

// File: rtl/char_uart_rx.sv
// char_uart_rx: 8N1 asynchronous serial receiver. It deserialises frames from bus.rx_in into
// bytes, pulses char_valid for one cycle per good byte and frame_err for one cycle per bad
// stop bit, and keeps a wrapping 16-bit count of good characters.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - char_uart_rx_if.master: rx_in in; char_out, char_valid, frame_err, busy and
//         rx_count out
// All outputs are registered.
module char_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic            clk,
    input logic            rst,
    char_uart_rx_if.master bus
);

    localparam int unsigned H    = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      char_out_q, char_out_d;
    logic            char_valid_q, char_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic [15:0]     rx_count_q, rx_count_d;

    always_comb begin
        state_d      = state_q;
        s1_d         = bus.rx_in;
        s2_d         = s1_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        rx_count_d   = rx_count_q;
        // busy lags the state register by one cycle
        busy_d       = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!s2_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (!s2_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went high again before mid start bit: treat as a glitch
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift right and insert at the MSB
                    shreg_d = {s2_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        char_out_d   = shreg_q;
                        char_valid_d = 1'b1;
                        rx_count_d   = rx_count_q + 16'd1;
                        // Return at mid stop bit so a back-to-back start edge is not missed
                        state_d      = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitIdle: begin
                // Hold here through a break so it reports only one framing error
                cnt_d = '0;
                if (s2_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shreg_q      <= 8'h00;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            rx_count_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            rx_count_q   <= rx_count_d;
        end
    end

    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
    assign bus.rx_count   = rx_count_q;

endmodule
